// File: rtl/rad_tgl_sched_pkg.sv
// Shared types and helpers for the toggle-handshake event scheduler.
package rad_tgl_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_DRAIN    = 2'd2
    } tgl_sched_state_e;

    // Requester index width, never narrower than one bit.
    function automatic int calc_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rad_pulse_gen.sv
// Registers a level and flags any change of it as a one-cycle pulse.
module rad_pulse_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic pulse_o
);

    logic q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o     = q_q;
    assign pulse_o = q_q ^ d_i;

endmodule

// File: rtl/rad_tgl_event_sched.sv
// Round-robin source scheduler for a shared toggle-handshake event channel.
// state    | meaning
// IDLE     | grant a requester when the channel is quiescent
// WAIT_ACK | event launched, waiting for the matching ack toggle
// DRAIN    | timed out, waiting for the late ack before reuse
module rad_tgl_event_sched
    import rad_tgl_sched_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int DATA_W  = 8,
    parameter  int TIMEOUT = 64,
    localparam int ID_W    = calc_id_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_tgl,
    output logic [DATA_W-1:0]       tx_data,
    output logic [ID_W-1:0]         tx_id,
    input  logic                    ack_tgl_sync,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int              CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit              TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    tgl_sched_state_e  state_q, state_d;
    logic              tx_tgl_q, tx_tgl_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [ID_W-1:0]   tx_id_q, tx_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              ack_q, ack_pulse, ack_match;
    logic              quiescent, xfer;
    logic [ID_W-1:0]   grant_idx;
    logic [N_REQ-1:0]  grant_oh;

    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                input logic [ID_W-1:0]  ptr);
        logic found;
        int   j;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && valid[j]) begin
                rr_pick = ID_W'(j);
                found   = 1'b1;
            end
        end
    endfunction

    rad_pulse_gen u_ack_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (ack_tgl_sync),
        .q_o     (ack_q),
        .pulse_o (ack_pulse)
    );

    // An edge whose previous level differs from tx_tgl lands on tx_tgl, i.e. a real ack.
    assign ack_match = ack_pulse && (ack_q != tx_tgl_q);
    assign quiescent = (ack_tgl_sync == tx_tgl_q);
    assign grant_idx = rr_pick(req_valid, rr_ptr_q);

    always_comb begin
        grant_oh = '0;
        if (state_q == ST_IDLE && quiescent && (|req_valid)) grant_oh[grant_idx] = 1'b1;
    end

    assign xfer = |(req_valid & grant_oh);

    always_comb begin
        state_d   = state_q;
        tx_tgl_d  = tx_tgl_q;
        tx_data_d = tx_data_q;
        tx_id_d   = tx_id_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    tx_tgl_d  = ~tx_tgl_q;
                    tx_data_d = req_data[grant_idx*DATA_W +: DATA_W];
                    tx_id_d   = grant_idx;
                    cnt_d     = '0;
                    rr_ptr_d  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_match) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    if (TO_EN && cnt_q == CNT_LAST) begin
                        state_d = ST_DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (quiescent) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_tgl_q  <= 1'b0;
            tx_data_q <= '0;
            tx_id_q   <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_tgl_q  <= tx_tgl_d;
            tx_data_q <= tx_data_d;
            tx_id_q   <= tx_id_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign req_ready   = grant_oh;
    assign tx_tgl      = tx_tgl_q;
    assign tx_data     = tx_data_q;
    assign tx_id       = tx_id_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = err_q;

endmodule
